// File: rtl/wm8731_pkg.sv
// Shared WM8731 definitions: register addresses, sequencer state encodings
// and the default power-up register table.
package wm8731_pkg;

  localparam logic [6:0] REG_LLINVOL = 7'h00;
  localparam logic [6:0] REG_RLINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT  = 7'h02;
  localparam logic [6:0] REG_RHPOUT  = 7'h03;
  localparam logic [6:0] REG_ANAPATH = 7'h04;
  localparam logic [6:0] REG_DIGPATH = 7'h05;
  localparam logic [6:0] REG_PWRDOWN = 7'h06;
  localparam logic [6:0] REG_IFACE   = 7'h07;
  localparam logic [6:0] REG_ACTIVE  = 7'h09;
  localparam logic [6:0] REG_RESET   = 7'h0F;

  typedef enum logic [3:0] {
    ST_PWR_WAIT = 4'd0,
    ST_ADDR     = 4'd1,
    ST_HI       = 4'd2,
    ST_LO       = 4'd3,
    ST_NEXT     = 4'd4,
    ST_BACKOFF  = 4'd5,
    ST_DONE     = 4'd6,
    ST_ERROR    = 4'd7
  } state_t;

  localparam int INIT_DEPTH = 10;

  // {reg[6:0], data[8:0]}; soft reset first, ACTIVE last so the codec only
  // starts once every other register is in place.
  function automatic logic [15:0] init_word(input logic [3:0] index);
    case (index)
      4'd0:    init_word = {REG_RESET,   9'h000};
      4'd1:    init_word = {REG_LLINVOL, 9'h017};
      4'd2:    init_word = {REG_RLINVOL, 9'h017};
      4'd3:    init_word = {REG_LHPOUT,  9'h079};
      4'd4:    init_word = {REG_RHPOUT,  9'h079};
      4'd5:    init_word = {REG_ANAPATH, 9'h012};
      4'd6:    init_word = {REG_DIGPATH, 9'h000};
      4'd7:    init_word = {REG_PWRDOWN, 9'h000};
      4'd8:    init_word = {REG_IFACE,   9'h002};
      4'd9:    init_word = {REG_ACTIVE,  9'h001};
      default: init_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/wm8731_init_rom.sv
// Combinational lookup of the WM8731 init table: index -> {reg[6:0], data[8:0]}.
module wm8731_init_rom
  import wm8731_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] entry
);

  // Table lookup; indices past the table return zero
  always_comb begin
    entry = init_word(index);
  end

endmodule

// File: rtl/wm8731_init_sequencer.sv
// Power-up configuration sequencer for the WM8731: walks the init table as
// 3-byte I2C writes through an external byte-level master, with retry/backoff.
module wm8731_init_sequencer
  import wm8731_pkg::*;
#(
  parameter logic [6:0] PERIPH_ADDR    = 7'b0011010,
  parameter int         NUM_REGS       = INIT_DEPTH,
  parameter int         POWERUP_CYCLES = 1000,
  parameter int         MAX_RETRIES    = 3,
  parameter int         BACKOFF_CYCLES = 256,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_byte,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_index,
  output logic [3:0] state_info
);

  // One counter serves power-up wait, backoff and response timeout
  localparam int MAX_WAIT_A = (POWERUP_CYCLES > BACKOFF_CYCLES) ? POWERUP_CYCLES : BACKOFF_CYCLES;
  localparam int MAX_WAIT   = (MAX_WAIT_A > TIMEOUT_CYCLES) ? MAX_WAIT_A : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] PWR_LAST     = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_INDEX   = 4'(NUM_REGS - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);
  localparam logic [7:0]       ADDR_BYTE    = {PERIPH_ADDR, 1'b0};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       index_r;
  logic [2:0]       retries_r;
  logic [15:0]      rom_entry_s;
  logic [6:0]       rom_reg_s;
  logic [8:0]       rom_data_s;
  logic             wait_rsp_s;
  logic             attempt_fail_s;

  wm8731_init_rom u_rom (
    .index (index_r),
    .entry (rom_entry_s)
  );

  assign rom_reg_s  = rom_entry_s[15:9];
  assign rom_data_s = rom_entry_s[8:0];
  assign state_info = state_r;

  // A byte is outstanding once its command has been accepted in a byte state
  assign wait_rsp_s = ((state_r == ST_ADDR) || (state_r == ST_HI) || (state_r == ST_LO)) && !cmd_valid;
  assign attempt_fail_s = wait_rsp_s &&
                          ((rsp_valid && rsp_nack) || (!rsp_valid && (cnt_r == TIMEOUT_LAST)));

  // Sequencer FSM with registered command and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_PWR_WAIT;
      cnt_r     <= '0;
      index_r   <= 4'd0;
      retries_r <= 3'd0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_byte  <= 8'h00;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= 4'd0;
    end else begin
      case (state_r)
        ST_PWR_WAIT: begin
          if (cnt_r == PWR_LAST) begin
            state_r   <= ST_ADDR;
            cmd_valid <= 1'b1;
            cmd_start <= 1'b1;
            cmd_stop  <= 1'b0;
            cmd_byte  <= ADDR_BYTE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_ADDR, ST_HI, ST_LO: begin
          if (cmd_valid) begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              cmd_start <= 1'b0;
              cmd_stop  <= 1'b0;
              cnt_r     <= '0;
            end
          end else if (attempt_fail_s) begin
            if (retries_r < RETRY_LIMIT) begin
              retries_r <= retries_r + 3'd1;
              cnt_r     <= '0;
              state_r   <= ST_BACKOFF;
            end else begin
              state_r   <= ST_ERROR;
              error     <= 1'b1;
              err_index <= index_r;
              busy      <= 1'b0;
            end
          end else if (rsp_valid) begin
            case (state_r)
              ST_ADDR: begin
                state_r   <= ST_HI;
                cmd_valid <= 1'b1;
                cmd_byte  <= {rom_reg_s, rom_data_s[8]};
              end
              ST_HI: begin
                state_r   <= ST_LO;
                cmd_valid <= 1'b1;
                cmd_stop  <= 1'b1;
                cmd_byte  <= rom_data_s[7:0];
              end
              default: state_r <= ST_NEXT;
            endcase
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          retries_r <= 3'd0;
          if (index_r == LAST_INDEX) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            index_r   <= index_r + 4'd1;
            state_r   <= ST_ADDR;
            cmd_valid <= 1'b1;
            cmd_start <= 1'b1;
            cmd_stop  <= 1'b0;
            cmd_byte  <= ADDR_BYTE;
          end
        end
        ST_BACKOFF: begin
          if (cnt_r == BACKOFF_LAST) begin
            state_r   <= ST_ADDR;
            cmd_valid <= 1'b1;
            cmd_start <= 1'b1;
            cmd_stop  <= 1'b0;
            cmd_byte  <= ADDR_BYTE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= 4'd0;
            index_r   <= 4'd0;
            retries_r <= 3'd0;
            busy      <= 1'b1;
            state_r   <= ST_ADDR;
            cmd_valid <= 1'b1;
            cmd_start <= 1'b1;
            cmd_stop  <= 1'b0;
            cmd_byte  <= ADDR_BYTE;
          end
        end
        default: begin
          state_r   <= ST_ERROR;
          error     <= 1'b1;
          err_index <= index_r;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_init_sequencer.sv
// Self-checking bench: behavioural I2C byte master with programmable
// NACK/drop/stall policy, compared against a transaction-level reference model.
module tb_wm8731_init_sequencer;

  localparam int NR = 10;
  localparam int PW = 20;
  localparam int MR = 3;
  localparam int BO = 16;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cmd_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_nack = 1'b0;
  logic cmd_valid, cmd_start, cmd_stop, busy, done, error;
  logic [7:0] cmd_byte;
  logic [3:0] err_index, state_info;

  wm8731_init_sequencer #(
    .PERIPH_ADDR(7'b0011010), .NUM_REGS(NR), .POWERUP_CYCLES(PW),
    .MAX_RETRIES(MR), .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .state_info(state_info)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Independent copy of the expected init table
  logic [6:0] ref_reg [NR];
  logic [8:0] ref_dat [NR];

  // Master policy (written by the main process only)
  int pe, pa, pe2, pa2, pp, kind;
  int stall_amt = 0, stall_req = 0, clr_req = 0;
  // Master observations (written by the master process only)
  logic [9:0] log_q [$];
  int cur_entry, m_attempt, m_pos, late_cnt, nack_cycle, min_gap, saw_nack;
  int late_fired = 0;
  int stab_viol = 0;

  logic [9:0] exp_q [$];
  bit exp_err;
  int exp_idx;
  int log_base;

  typedef struct {
    int pe; int pa; int pe2; int pa2; int pp; int kind; int stall;
    bit exp_done; bit exp_err; int exp_idx;
  } scn_t;
  scn_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit fail_now(int e, int a);
    return (e == pe && a <= pa) || (e == pe2 && a <= pa2);
  endfunction

  // {byte, start, stop} for byte p of entry e
  function automatic logic [9:0] exp_cmd(int e, int p);
    logic [9:0] r;
    if (p == 0)      r = {8'h34, 1'b1, 1'b0};
    else if (p == 1) r = {ref_reg[e], ref_dat[e][8], 1'b0, 1'b0};
    else             r = {ref_dat[e][7:0], 1'b0, 1'b1};
    return r;
  endfunction

  function automatic void build_model();
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int e = 0; e < NR; e++) begin
      for (int a = 1; a <= MR + 1; a++) begin
        bit f;
        int last;
        f = fail_now(e, a);
        last = f ? pp : 2;
        for (int p = 0; p <= last; p++) exp_q.push_back(exp_cmd(e, p));
        if (!f) break;
        if (a == MR + 1) begin
          exp_err = 1'b1;
          exp_idx = e;
          return;
        end
      end
    end
  endfunction

  // Behavioural byte master
  initial begin : master
    int phase, stall, lat, pend_nack, clr_seen, stall_seen;
    logic [9:0] cap;
    phase = 0; stall = 0; lat = 0; pend_nack = 0; clr_seen = 0; stall_seen = 0; cap = '0;
    forever begin
      @(posedge clk); #2;
      rsp_valid = 1'b0;
      rsp_nack = 1'b0;
      if (reset || clr_req != clr_seen) begin
        clr_seen = clr_req; phase = 0; cmd_ready = 1'b0;
        cur_entry = 0; m_attempt = 0; m_pos = 0; late_cnt = 0;
        nack_cycle = -1; min_gap = 1000000; saw_nack = 0;
        continue;
      end
      if (late_cnt > 0) begin
        late_cnt--;
        if (late_cnt == 0) begin
          rsp_valid = 1'b1;
          late_fired++;
        end
      end
      case (phase)
        0: if (cmd_valid) begin
          cap = {cmd_byte, cmd_start, cmd_stop};
          if (cmd_start && nack_cycle >= 0) begin
            if (cyc - nack_cycle < min_gap) min_gap = cyc - nack_cycle;
            nack_cycle = -1;
          end
          if (stall_req != stall_seen) begin
            stall_seen = stall_req;
            stall = stall_amt;
          end else begin
            stall = $urandom_range(0, 2);
          end
          if (stall == 0) begin cmd_ready = 1'b1; phase = 2; end
          else phase = 1;
        end
        1: begin
          stall--;
          if (stall == 0) begin cmd_ready = 1'b1; phase = 2; end
        end
        2: begin
          bit f;
          cmd_ready = 1'b0;
          log_q.push_back(cap);
          if (cap[1]) begin m_attempt++; m_pos = 0; end
          else m_pos++;
          f = (m_pos == pp) && fail_now(cur_entry, m_attempt);
          if (!f && m_pos == 2) begin cur_entry++; m_attempt = 0; end
          if (f && kind == 1) begin
            late_cnt = TO + 8;
            phase = 0;
          end else begin
            pend_nack = f;
            lat = $urandom_range(1, 4);
            phase = 3;
          end
        end
        default: begin
          lat--;
          if (lat == 0) begin
            rsp_valid = 1'b1;
            rsp_nack = pend_nack[0];
            if (pend_nack != 0) begin nack_cycle = cyc; saw_nack = 1; end
            phase = 0;
          end
        end
      endcase
    end
  end

  // Payload must hold while a command waits for acceptance
  always @(negedge clk) begin : stab_mon
    logic pv, pr;
    logic [9:0] pl;
    if (!reset && pv && !pr && (cmd_valid !== 1'b1 || {cmd_byte, cmd_start, cmd_stop} !== pl))
      stab_viol <= stab_viol + 1;
    pv = reset ? 1'b0 : cmd_valid;
    pr = cmd_ready;
    pl = {cmd_byte, cmd_start, cmd_stop};
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state_info, 32'd0);
    chk({tag, "_valid"}, {cmd_valid, cmd_start, cmd_stop}, 32'd0);
    chk({tag, "_byte"}, cmd_byte, 32'd0);
    chk({tag, "_flags"}, {busy, done, error, err_index}, 32'h40);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_base = log_q.size();
  endtask

  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 20000; k++) begin
      if (done || error) break;
      @(posedge clk); #1;
    end
    checks++;
    if (!(done || error)) begin
      failures++;
      $display("FAIL %s_timeout actual=no_end required=done_or_error", tag);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    n = log_q.size() - log_base;
    chk({tag, "_ncmd"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), log_q[log_base + i], exp_q[i]);
  endtask

  task automatic run_scn(input scn_t s, input bit use_tbl, input int id);
    string tag;
    int sv, lf, k, act_cnt;
    bit d, er;
    int ei;
    tag = $sformatf("scn%0d", id);
    pe = s.pe; pa = s.pa; pe2 = s.pe2; pa2 = s.pa2; pp = s.pp; kind = s.kind;
    build_model();
    if (s.stall > 0) begin stall_amt = s.stall; stall_req++; end
    sv = stab_viol; lf = late_fired;
    do_reset();
    if (id == 0) begin
      k = 0;
      while (!cmd_valid && k < PW + 10) begin @(posedge clk); #1; k++; end
      chk("powerup_wait", (k >= PW && k <= PW + 1), 32'd1);
    end
    wait_end(tag);
    d  = use_tbl ? s.exp_done : !exp_err;
    er = use_tbl ? s.exp_err : exp_err;
    ei = use_tbl ? s.exp_idx : exp_idx;
    chk({tag, "_done"}, done, d);
    chk({tag, "_error"}, error, er);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_state"}, state_info, er ? 32'd7 : 32'd6);
    if (er) chk({tag, "_err_index"}, err_index, ei);
    act_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cmd_valid) act_cnt++;
    end
    chk({tag, "_idle"}, act_cnt, 32'd0);
    cmp_stream(tag);
    chk({tag, "_stable"}, stab_viol - sv, 32'd0);
    if (saw_nack != 0) chk({tag, "_backoff_gap"}, min_gap >= BO, 32'd1);
    if (s.kind == 1 && s.pe >= 0 && s.pa > 0) chk({tag, "_late_rsp_seen"}, late_fired > lf, 32'd1);
  endtask

  task automatic clean_policy();
    pe = -1; pa = 0; pe2 = -1; pa2 = 0; pp = 0; kind = 0;
    build_model();
  endtask

  initial begin
    int k;
    scn_t r;
    ref_reg[0] = 7'h0F; ref_dat[0] = 9'h000;
    ref_reg[1] = 7'h00; ref_dat[1] = 9'h017;
    ref_reg[2] = 7'h01; ref_dat[2] = 9'h017;
    ref_reg[3] = 7'h02; ref_dat[3] = 9'h079;
    ref_reg[4] = 7'h03; ref_dat[4] = 9'h079;
    ref_reg[5] = 7'h04; ref_dat[5] = 9'h012;
    ref_reg[6] = 7'h05; ref_dat[6] = 9'h000;
    ref_reg[7] = 7'h06; ref_dat[7] = 9'h000;
    ref_reg[8] = 7'h07; ref_dat[8] = 9'h002;
    ref_reg[9] = 7'h09; ref_dat[9] = 9'h001;
    //          pe  pa  pe2 pa2 pp kind stall done err idx
    tbl[0] = '{-1,  0, -1,  0,  0, 0,   0,   1'b1, 1'b0, 0};
    tbl[1] = '{ 2,  2, -1,  0,  0, 0,   0,   1'b1, 1'b0, 0};
    tbl[2] = '{ 2,  3,  3,  1,  0, 0,   0,   1'b1, 1'b0, 0};
    tbl[3] = '{ 4, 99, -1,  0,  0, 0,   0,   1'b0, 1'b1, 4};
    tbl[4] = '{ 1,  1, -1,  0,  0, 1,   0,   1'b1, 1'b0, 0};
    tbl[5] = '{-1,  0, -1,  0,  0, 0,  50,   1'b1, 1'b0, 0};
    tbl[6] = '{ 6,  3, -1,  0,  2, 0,   0,   1'b1, 1'b0, 0};
    tbl[7] = '{ 9,  4, -1,  0,  1, 1,   0,   1'b0, 1'b1, 9};
    clean_policy();

    for (int i = 0; i < 8; i++) run_scn(tbl[i], 1'b1, i);

    for (int i = 0; i < 3; i++) begin
      r = '{$urandom_range(0, NR - 1), $urandom_range(0, 5), -1, 0,
            $urandom_range(0, 2), $urandom_range(0, 1), 0, 1'b0, 1'b0, 0};
      run_scn(r, 1'b0, 10 + i);
    end

    // start while in ERROR re-runs from entry 0 without power-up wait
    run_scn(tbl[3], 1'b1, 20);
    clean_policy();
    clr_req++;
    log_base = log_q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_flags", {busy, done, error, err_index}, 32'h40);
    chk("restart_state", state_info, 32'd1);
    chk("restart_valid", {cmd_valid, cmd_start, cmd_byte}, {2'b11, 8'h34});
    wait_end("restart");
    chk("restart_done", {done, error}, 32'd2);
    cmp_stream("restart");

    // start while busy is ignored
    clean_policy();
    do_reset();
    k = 0;
    while (log_q.size() - log_base < 4 && k < 2000) begin @(posedge clk); #1; k++; end
    chk("busy_reach", log_q.size() - log_base >= 4, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_flags", {busy, done, error}, 32'd4);
    wait_end("busy_start");
    chk("busy_start_done", {done, error}, 32'd2);
    cmp_stream("busy_start");

    // reset in the middle of an HI byte
    clean_policy();
    do_reset();
    k = 0;
    while (state_info != 4'd2 && k < 2000) begin @(posedge clk); #1; k++; end
    chk("hi_reach", state_info, 32'd2);
    reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge clk); #1;
    chk_reset_vals("midrst_next");
    @(posedge clk); #1;
    reset = 1'b0;
    log_base = log_q.size();
    wait_end("midrst");
    chk("midrst_done", {done, error}, 32'd2);
    cmp_stream("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
